// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver state encoding, frame levels and scan codes
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    localparam int DATA_BITS = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: 2-flop synchroniser, level glitch filter and filtered falling-edge pulse
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic fall_edge
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic accept;
    assign accept = (sync[1] != level) && (cnt == LAST);
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync <= 2'b11;
            cnt <= '0;
            level <= 1'b1;
            fall_edge <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            cnt <= (sync[1] == level || accept) ? '0 : cnt + CW'(1);
            level <= accept ? sync[1] : level;
            fall_edge <= accept && !sync[1];
        end
    end
endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: deframes 11-bit PS/2 device frames into a byte plus strobe, with parity/framing/timeout errors
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] ps2_key_data,
    output logic       ps2_key_pressed,
    output logic       ps2_rx_error,
    output logic       ps2_busy
);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    ps2_state_t state, state_d;
    logic [2:0] bit_cnt, bit_d;
    logic [7:0] shift, shift_d, key_d;
    logic par, par_d, pressed_d, err_d;
    logic [WW-1:0] wd, wd_d;
    logic fall, dat, clk_level_unused, dat_fall_unused;
    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .raw(PS2_CLK),
        .level(clk_level_unused), .fall_edge(fall)
    );
    // Data only needs synchronising; a 1-cycle filter is a plain extra flop
    ps2_clk_filter #(.FILTER_LEN(1)) u_dat (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .raw(PS2_DAT),
        .level(dat), .fall_edge(dat_fall_unused)
    );
    assign ps2_busy = state != IDLE;
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            bit_cnt <= '0;
            shift <= '0;
            par <= 1'b0;
            wd <= '0;
            ps2_key_data <= '0;
            ps2_key_pressed <= 1'b0;
            ps2_rx_error <= 1'b0;
        end else begin
            state <= state_d;
            bit_cnt <= bit_d;
            shift <= shift_d;
            par <= par_d;
            wd <= wd_d;
            ps2_key_data <= key_d;
            ps2_key_pressed <= pressed_d;
            ps2_rx_error <= err_d;
        end
    end
    always_comb begin
        state_d = state;
        bit_d = bit_cnt;
        shift_d = shift;
        par_d = par;
        key_d = ps2_key_data;
        pressed_d = 1'b0;
        err_d = 1'b0;
        wd_d = (fall || state == IDLE) ? '0 : (wd == '1 ? wd : wd + WW'(1));
        case (state)
            IDLE: if (fall) begin
                if (dat == START_LEVEL) begin
                    state_d = DATA;
                    bit_d = '0;
                    shift_d = '0;
                end else err_d = 1'b1;
            end
            DATA: if (fall) begin
                shift_d = {dat, shift[7:1]};
                bit_d = bit_cnt + 3'd1;
                state_d = bit_cnt == LAST_BIT ? PARITY : DATA;
            end
            PARITY: if (fall) begin
                par_d = dat;
                state_d = STOP;
            end
            STOP: if (fall) begin
                if (dat == STOP_LEVEL && (^shift ^ par)) begin
                    key_d = shift;
                    pressed_d = 1'b1;
                end else err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A fall_edge in the timeout cycle keeps the frame alive
        if (state != IDLE && wd == WD_LAST && !fall) begin
            state_d = IDLE;
            err_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: directed and random PS/2 frames checked against a frame-level reference model
module tb_ps2_frame_receiver;
    localparam int FL = 8;
    localparam int TO = 2000;
    localparam int H = 50;
    logic CLOCK_50 = 1'b0;
    logic resetn = 1'b0;
    logic PS2_CLK = 1'b1;
    logic PS2_DAT = 1'b1;
    logic [7:0] ps2_key_data;
    logic ps2_key_pressed, ps2_rx_error, ps2_busy;
    int n_cmp = 0, n_bad = 0;
    int n_press = 0, n_err = 0, run = 0, max_run = 0, both = 0;
    logic [7:0] got[$];
    logic [7:0] exp_key = 8'h00;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .ps2_key_data(ps2_key_data), .ps2_key_pressed(ps2_key_pressed),
        .ps2_rx_error(ps2_rx_error), .ps2_busy(ps2_busy)
    );

    always @(negedge CLOCK_50) begin
        if (ps2_key_pressed) begin
            n_press <= n_press + 1;
            got.push_back(ps2_key_data);
            run <= run + 1;
            if (run + 1 > max_run) max_run <= run + 1;
        end else run <= 0;
        if (ps2_rx_error) n_err <= n_err + 1;
        if (ps2_key_pressed && ps2_rx_error) both <= both + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit stop);
        logic p;
        p = ($countones(b) % 2 == 0) ^ bad_par;
        return {stop, p, b, 1'b0};
    endfunction

    function automatic bit frame_ok(input logic [10:0] f);
        return f[0] == 1'b0 && f[10] == 1'b1 && ($countones(f[9:1]) % 2 == 1);
    endfunction

    task automatic send_raw(input logic [10:0] f, input int n, input int gb);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = f[i];
            tick(H);
            if (i == gb) begin
                PS2_CLK = 1'b0;
                tick(3);
                PS2_CLK = 1'b1;
                tick(H);
            end
            PS2_CLK = 1'b0;
            tick(H);
            PS2_CLK = 1'b1;
        end
    endtask

    task automatic frame_check(input string tag, input logic [7:0] b, input bit bad_par,
                               input bit stop, input int gb);
        logic [10:0] f;
        int p0, e0;
        bit ok;
        f = mk(b, bad_par, stop);
        ok = frame_ok(f);
        p0 = n_press;
        e0 = n_err;
        send_raw(f, 11, gb);
        tick(5);
        if (ok) exp_key = b;
        chk({tag, ".press"}, n_press - p0, ok ? 1 : 0);
        chk({tag, ".err"}, n_err - e0, ok ? 0 : 1);
        chk({tag, ".data"}, {24'd0, ps2_key_data}, {24'd0, exp_key});
        chk({tag, ".busy"}, {31'd0, ps2_busy}, 0);
    endtask

    initial begin
        int e0;
        logic [7:0] rb;
        tick(3);
        chk("rst.data", {24'd0, ps2_key_data}, 0);
        chk("rst.press", {31'd0, ps2_key_pressed}, 0);
        chk("rst.err", {31'd0, ps2_rx_error}, 0);
        chk("rst.busy", {31'd0, ps2_busy}, 0);
        resetn = 1'b1;
        tick(10);
        frame_check("w", 8'h1D, 0, 1, -1);
        frame_check("b2b0", 8'hF0, 0, 1, -1);
        frame_check("b2b1", 8'h1D, 0, 1, -1);
        chk("b2b.q0", {24'd0, got[got.size()-2]}, 32'hF0);
        chk("b2b.q1", {24'd0, got[got.size()-1]}, 32'h1D);
        frame_check("badpar", 8'h23, 1, 1, -1);
        frame_check("badstop", 8'h1C, 0, 0, -1);
        frame_check("a", 8'h1C, 0, 1, -1);
        e0 = n_err;
        PS2_CLK = 1'b0;
        tick(3);
        PS2_CLK = 1'b1;
        tick(20);
        chk("glitch.idle.busy", {31'd0, ps2_busy}, 0);
        chk("glitch.idle.err", n_err - e0, 0);
        frame_check("glitch.s", 8'h1B, 0, 1, 3);
        e0 = n_err;
        send_raw(mk(8'h5A, 0, 1), 6, -1);
        tick(5);
        chk("to.busy_mid", {31'd0, ps2_busy}, 1);
        tick(TO);
        chk("to.err", n_err - e0, 1);
        chk("to.busy", {31'd0, ps2_busy}, 0);
        chk("to.data", {24'd0, ps2_key_data}, {24'd0, exp_key});
        frame_check("to.next", 8'hF0, 0, 1, -1);
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            frame_check($sformatf("rnd%0d", i), rb, $urandom_range(3) == 0, $urandom_range(3) != 0, -1);
        end
        send_raw(mk(8'hA5, 0, 1), 4, -1);
        tick(5);
        chk("rstmid.busy_before", {31'd0, ps2_busy}, 1);
        resetn = 1'b0;
        #1;
        exp_key = 8'h00;
        chk("rstmid.data", {24'd0, ps2_key_data}, 0);
        chk("rstmid.busy", {31'd0, ps2_busy}, 0);
        chk("rstmid.press", {31'd0, ps2_key_pressed}, 0);
        chk("rstmid.err", {31'd0, ps2_rx_error}, 0);
        PS2_DAT = 1'b1;
        tick(2);
        resetn = 1'b1;
        tick(20);
        frame_check("rstmid.next", 8'hF0, 0, 1, -1);
        chk("strobe.width", max_run, 1);
        chk("strobe.excl", both, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Serial PS/2 keyboard receiver. Deframes the 11-bit device-to-host PS/2 frame on PS2_CLK/PS2_DAT into a byte plus a one-cycle strobe.
- Sits directly upstream of the WASD movement/display block and drives its ps2_key_data / ps2_key_pressed inputs.
- Receive-only; never drives the PS/2 lines. Filters clock glitches, checks parity and framing, and recovers from truncated frames via a watchdog.

Parameters:
- FILTER_LEN, 8: consecutive CLOCK_50 cycles the synchronised PS2_CLK must hold a new level before the filter accepts it.
- TIMEOUT_CYCLES, 50000: idle cycles (1 ms at 50 MHz) without a filtered falling edge mid-frame before the frame is abandoned.

Ports:
- CLOCK_50 input 1: system clock, 50 MHz.
- resetn input 1: asynchronous, active-low reset.
- PS2_CLK input 1: raw PS/2 clock from the device, asynchronous.
- PS2_DAT input 1: raw PS/2 data from the device, asynchronous.
- ps2_key_data output 8: last correctly received byte.
- ps2_key_pressed output 1: one-cycle strobe when ps2_key_data updates.
- ps2_rx_error output 1: one-cycle strobe on parity, framing or timeout error.
- ps2_busy output 1: high while a frame is in progress (state != IDLE).

Behaviour:
- Interface: one clock, CLOCK_50. Reset resetn is asynchronous and active-low.
- Reset values: ps2_key_data=8'h00, ps2_key_pressed=0, ps2_rx_error=0, ps2_busy=0, FSM=IDLE. All counters 0. Filtered clock=1. Sync flops=1.
- Synchronisation: PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser.
- Clock filter: the filtered clock changes only after the synchronised clock has differed from it for FILTER_LEN consecutive cycles. Any shorter pulse is discarded and the counter clears.
- fall_edge: one-cycle pulse on a filtered 1->0 transition. Data is sampled from synchronised PS2_DAT in the fall_edge cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - fall_edge with data=0 (start bit) -> DATA; bit_cnt=0; shift register cleared.
  - fall_edge with data=1 -> stay IDLE and pulse ps2_rx_error.
- DATA: on each fall_edge, shift the bit in LSB-first (new bit into bit 7, shift right). After the 8th bit (bit_cnt==7) -> PARITY.
- PARITY: on fall_edge, latch the parity bit -> STOP.
- STOP, on fall_edge:
  - Stop bit=1 and (XOR of 8 data bits XOR parity)==1 (odd parity): ps2_key_data<=shift register, ps2_key_pressed=1 for exactly one cycle.
  - Otherwise: ps2_rx_error=1 for one cycle and ps2_key_data is unchanged.
  - Both cases -> IDLE.
- Latency: the strobe and new data are registered and visible on the cycle after the stop-bit fall_edge cycle.
- Strobe exclusivity: ps2_key_pressed and ps2_rx_error are never high together.
- Watchdog:
  - Counter clears on every fall_edge and in IDLE, and increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 in DATA, PARITY or STOP -> IDLE, one-cycle ps2_rx_error, partial byte discarded.
  - If the timeout and a fall_edge occur in the same cycle, the fall_edge wins.
- Back-to-back frames: a start bit arriving on the first fall_edge after returning to IDLE is accepted. No gap is required beyond the stop bit.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The remainder of the interrupted frame is handled by the start-bit/error/timeout rules.
- Width rules: bit_cnt is 3 bits. The filter counter is $clog2(FILTER_LEN+1) bits. The watchdog is $clog2(TIMEOUT_CYCLES) bits and saturates rather than wraps.

Decomposition:
- Package ps2_pkg:
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - Frame constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1.
  - Scan-code constants used downstream: BREAK_CODE=8'hF0, KEY_W=8'h1D, KEY_A=8'h1C, KEY_S=8'h1B, KEY_D=8'h23.
- Sub-module ps2_clk_filter: synchroniser, glitch filter and fall_edge generator, parameterised by FILTER_LEN. Reused for PS2_DAT synchronisation with FILTER_LEN=1.

Test Plan:
- Send frame 0x1D (start 0, bits LSB-first, parity 1, stop 1) at a 15 kHz PS/2 clock -> ps2_key_data=8'h1D, ps2_key_pressed high for exactly 1 cycle, ps2_rx_error stays 0.
- Send 0xF0 then 0x1D back-to-back with minimal gap -> two strobes, data 8'hF0 then 8'h1D, ps2_busy low only between frames.
- Send 0x23 with parity bit inverted -> ps2_rx_error pulses once, no ps2_key_pressed, ps2_key_data keeps its previous value.
- Send 0x1C with stop bit 0 -> ps2_rx_error pulse. A following valid 0x1C -> data=8'h1C with strobe.
- Inject 3-cycle low glitches on PS2_CLK during IDLE and mid-DATA -> no state change, bit_cnt unchanged. The frame completes with correct byte 0x1B.
- Abort a frame after 5 data bits and hold PS2_CLK high for TIMEOUT_CYCLES -> one ps2_rx_error pulse, FSM back in IDLE. The next frame 0xF0 is received correctly. Also assert resetn low mid-frame -> outputs return to reset values at once.
